// File: rtl/filter_seq_pkg.sv
// Shared constants for the pixel filter sequencer: default widths and FSM state codes.
package filter_seq_pkg;

  localparam int SRC_ADDR_BITS_DEF = 15;
  localparam int DST_ADDR_BITS_DEF = 13;
  localparam int PIX_W_DEF         = 24;
  localparam int GRAY_W            = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RD    = 3'd1;
  localparam state_t ST_LATCH = 3'd2;
  localparam state_t ST_WR    = 3'd3;
  localparam state_t ST_NEXT  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/filter_seq_ctrl_cnt.sv
// Loadable pixel index / written-pixel counter with terminal compare against the latched frame length.
module seq_addr_cnt #(
  parameter int SRC_BITS = 15,
  parameter int DST_BITS = 13
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic                inc_i,
  input  logic [SRC_BITS:0]   len_i,
  output logic [SRC_BITS:0]   pix_cnt_o,
  output logic [SRC_BITS-1:0] nxt_addr_o,
  output logic [DST_BITS-1:0] dst_idx_o,
  output logic                last_o
);

  logic [SRC_BITS:0] len_q, len_d;
  logic [SRC_BITS:0] idx_q, idx_d;
  logic [SRC_BITS:0] pix_q, pix_d;
  logic [SRC_BITS:0] idx_inc_s;

  assign idx_inc_s  = idx_q + {{SRC_BITS{1'b0}}, 1'b1};
  assign last_o     = (idx_inc_s == len_q);
  assign nxt_addr_o = idx_inc_s[SRC_BITS-1:0];
  assign dst_idx_o  = idx_q[DST_BITS-1:0];
  assign pix_cnt_o  = pix_q;

  always_comb begin
    len_d = len_q;
    idx_d = idx_q;
    pix_d = pix_q;
    if (load_i) begin
      len_d = len_i;
      idx_d = '0;
      pix_d = '0;
    end else if (inc_i) begin
      idx_d = idx_inc_s;
      pix_d = pix_q + {{SRC_BITS{1'b0}}, 1'b1};
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      len_q <= '0;
      idx_q <= '0;
      pix_q <= '0;
    end else begin
      len_q <= len_d;
      idx_q <= idx_d;
      pix_q <= pix_d;
    end
  end

endmodule

// File: rtl/filter_seq_ctrl.sv
// Frame sequencer: reads source pixels, hands each to an external filter and writes the gray result,
// one pixel every four cycles, with abort at pixel boundaries.
module filter_seq_ctrl
  import filter_seq_pkg::*;
#(
  parameter int SRC_ADDR_BITS = SRC_ADDR_BITS_DEF,
  parameter int DST_ADDR_BITS = DST_ADDR_BITS_DEF,
  parameter int PIX_W         = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [SRC_ADDR_BITS:0]   num_pixels,
  output logic [SRC_ADDR_BITS-1:0] src_addr,
  input  logic [PIX_W-1:0]         src_data,
  output logic [PIX_W-1:0]         flt_pixel,
  input  logic [GRAY_W-1:0]        flt_ret,
  output logic [DST_ADDR_BITS-1:0] dst_addr,
  output logic                     dst_we,
  output logic [GRAY_W-1:0]        dst_data,
  output logic                     busy,
  output logic                     done,
  output logic [SRC_ADDR_BITS:0]   pix_cnt
);

  state_t                   state_q, state_d;
  logic                     abort_pend_q, abort_pend_d;
  logic [SRC_ADDR_BITS-1:0] src_addr_q, src_addr_d;
  logic [DST_ADDR_BITS-1:0] dst_addr_q, dst_addr_d;
  logic [PIX_W-1:0]         flt_pixel_q, flt_pixel_d;
  logic                     dst_we_q, busy_q, done_q;
  logic                     load_s, inc_s, last_s;
  logic [SRC_ADDR_BITS-1:0] nxt_addr_s;
  logic [DST_ADDR_BITS-1:0] dst_idx_s;

  seq_addr_cnt #(
    .SRC_BITS (SRC_ADDR_BITS),
    .DST_BITS (DST_ADDR_BITS)
  ) u_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (load_s),
    .inc_i      (inc_s),
    .len_i      (num_pixels),
    .pix_cnt_o  (pix_cnt),
    .nxt_addr_o (nxt_addr_s),
    .dst_idx_o  (dst_idx_s),
    .last_o     (last_s)
  );

  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    inc_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (num_pixels != '0)) begin
          load_s  = 1'b1;
          state_d = ST_RD;
        end else if (start) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD:    state_d = ST_LATCH;
      ST_LATCH: state_d = ST_WR;
      ST_WR:    state_d = ST_NEXT;
      ST_NEXT: begin
        inc_s = 1'b1;
        if (last_s || abort_pend_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output registers are loaded on the transition into the state that presents them.
  always_comb begin
    abort_pend_d = (state_q == ST_IDLE) ? 1'b0 : (abort_pend_q | abort);
    src_addr_d   = src_addr_q;
    dst_addr_d   = dst_addr_q;
    flt_pixel_d  = flt_pixel_q;
    if (state_d == ST_RD) begin
      src_addr_d = load_s ? '0 : nxt_addr_s;
    end else begin
      src_addr_d = src_addr_q;
    end
    if (state_d == ST_WR) begin
      dst_addr_d = dst_idx_s;
    end else begin
      dst_addr_d = dst_addr_q;
    end
    if (state_q == ST_LATCH) begin
      flt_pixel_d = src_data;
    end else begin
      flt_pixel_d = flt_pixel_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      abort_pend_q <= 1'b0;
      src_addr_q   <= '0;
      dst_addr_q   <= '0;
      flt_pixel_q  <= '0;
      dst_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      abort_pend_q <= abort_pend_d;
      src_addr_q   <= src_addr_d;
      dst_addr_q   <= dst_addr_d;
      flt_pixel_q  <= flt_pixel_d;
      dst_we_q     <= (state_d == ST_WR);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  // The filter result only becomes valid once flt_pixel is registered, so it is gated, not registered.
  assign dst_data  = dst_we_q ? flt_ret : {GRAY_W{1'b0}};
  assign src_addr  = src_addr_q;
  assign dst_addr  = dst_addr_q;
  assign flt_pixel = flt_pixel_q;
  assign dst_we    = dst_we_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/filter_seq_ctrl.md
FILTER_SEQ_CTRL -- requirements
Module: filter_seq_ctrl

Interface
REQ-001 Parameter SRC_ADDR_BITS, default 15, source RAM address width.
REQ-002 Parameter DST_ADDR_BITS, default 13, destination RAM address width.
REQ-003 Parameter PIX_W, default 24, source pixel width (R,G,B 8 bits each).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-007 abort  in  1  stop current frame at next pixel boundary.
REQ-008 num_pixels  in  SRC_ADDR_BITS+1  pixel count, latched on accepted start.
REQ-009 src_addr  out  SRC_ADDR_BITS  source RAM address (synchronous read, 1-cycle latency).
REQ-010 src_data  in  PIX_W  source RAM read data.
REQ-011 flt_pixel  out  PIX_W  registered pixel presented to the external filter.
REQ-012 flt_ret  in  8  combinational filter result for flt_pixel.
REQ-013 dst_addr  out  DST_ADDR_BITS  destination RAM address.
REQ-014 dst_we  out  1  destination write strobe.
REQ-015 dst_data  out  8  gray value written to destination.
REQ-016 busy  out  1  high from accepted start until DONE exits.
REQ-017 done  out  1  one-cycle pulse at frame end (normal or aborted).
REQ-018 pix_cnt  out  SRC_ADDR_BITS+1  pixels written so far this frame (for 7-seg display).

Function
REQ-019 FSM states: IDLE, RD, LATCH, WR, NEXT, DONE.
REQ-020 IDLE: start=1 and num_pixels!=0 -> latch length, index<=0, pix_cnt<=0, go RD; start=1 with num_pixels=0 -> DONE directly; otherwise stay.
REQ-021 RD: src_addr=index[SRC_ADDR_BITS-1:0]; go LATCH.
REQ-022 LATCH: flt_pixel<=src_data; go WR.
REQ-023 WR: dst_we=1 for exactly this cycle, dst_addr=index[DST_ADDR_BITS-1:0], dst_data=flt_ret; go NEXT.
REQ-024 NEXT: index<=index+1, pix_cnt<=pix_cnt+1; if index+1==length or abort_pend -> DONE, else RD.
REQ-025 DONE: done=1 one cycle, busy=1; go IDLE.
REQ-026 Throughput fixed at 4 cycles per pixel; first dst_we 3 cycles after start is accepted (start at edge N -> RD at N+1, dst_we in cycle N+3).
REQ-027 dst_we never asserted outside WR; src_addr and dst_addr hold last values otherwise.
REQ-028 abort sets abort_pend at any cycle while busy; the in-flight pixel completes its write; abort_pend cleared in IDLE.
REQ-029 abort and start in the same IDLE cycle: start accepted, abort ignored.
REQ-030 start while busy ignored; num_pixels changes while busy ignored.
REQ-031 length > 2^DST_ADDR_BITS: dst_addr wraps modulo 2^DST_ADDR_BITS; src_addr never wraps (max length 2^SRC_ADDR_BITS).
REQ-032 Index counter SRC_ADDR_BITS+1 bits wide, unsigned; comparison against latched length, not live input.

Reset
REQ-033 reset asserted: state=IDLE, index=0, pix_cnt=0, abort_pend=0, flt_pixel=0, src_addr=0, dst_addr=0, dst_we=0, dst_data=0, busy=0, done=0, asynchronously.
REQ-034 Reset mid-frame discards the frame; no done pulse; no further dst_we until a new start.

Structure
REQ-035 Shared package filter_seq_pkg holds state enumeration and default width constants (15, 13, 24, 8).
REQ-036 One sub-module seq_addr_cnt: loadable index/pix_cnt counter with terminal-compare output; FSM and registers in filter_seq_ctrl.
REQ-037 Filter stays external; controller contains no pixel arithmetic.

Verification
REQ-038 num_pixels=3, src 0..2 = 24'h102030/24'hFFFFFF/24'h000000, filter model avg -> dst[0..2]=8'h20/8'hFF/8'h00, done 12 cycles after first RD, pix_cnt=3.
REQ-039 num_pixels=0, start -> done pulse cycle after start, no dst_we, busy high exactly 1 cycle.
REQ-040 num_pixels=8, abort during 3rd pixel's LATCH -> 3 writes (addrs 0..2), then done, pix_cnt=3.
REQ-041 num_pixels=8194, DST_ADDR_BITS=13 -> last two writes at dst_addr 0 and 1, src_addr reaches 8193.
REQ-042 reset asserted during WR of pixel 5 of 10 -> all outputs zero same cycle, no done, idle until next start.
REQ-043 start pulsed again at pixel 2 of 4 -> ignored; exactly 4 writes, one done.
